gf163_mult: RTL and testbench
=============================

// Module: gf163_mult
// PURPOSE
//  Sequential bit-serial multiplier over GF(2^163), polynomial basis.
//  Field polynomial f(x) = x^163 + x^7 + x^6 + x^3 + 1 (NIST B/K-163).
//  Arithmetic core of the ECDH point-arithmetic datapath: takes two field
//  elements on a start pulse and returns A*B mod f(x) with a done pulse.
// PARAMETERS
//  NUM_BITS  163  field degree m; bus width is NUM_BITS+1 (164 bits).
// PORTS
//  clk      in   1    rising-edge clock (single clock domain)
//  n_rst    in   1    asynchronous, active-low reset
//  A        in   164  multiplicand; bits [162:0] used, bit 163 ignored (treated as 0)
//  B        in   164  multiplier; bits [162:0] used, bit 163 ignored (treated as 0)
//  start    in   1    request; sampled on rising clk, acted on only in IDLE
//  Product  out  164  registered result A*B mod f; bit 163 always 0
//  done     out  1    one-cycle pulse; Product is valid from this cycle on
// BEHAVIOUR
//  - Reset (n_rst=0, async): state=IDLE, Product=0, done=0, accumulator=0,
//    operand regs=0, bit counter=0. Reset mid-computation aborts it; no done.
//  - FSM: IDLE -> RUN -> DONE -> IDLE.
//    IDLE: when start=1 at an edge, latch A[162:0], B[162:0], clear acc,
//          counter=162, go RUN. Otherwise stay; done=0.
//    RUN: each edge, i=counter (162 down to 0):
//          acc_sh = acc<<1; if acc[162] then acc_sh ^= 0xC9 (bits 7,6,3,0),
//          truncated to 163 bits; acc = acc_sh ^ (B[i] ? A : 0).
//          163 iterations total (MSB-first Horner). On the i=0 edge, load
//          Product with the final acc value and go DONE.
//    DONE: done=1 for exactly one cycle; next edge -> IDLE.
//  - Latency: start captured at edge E0; done high after edge E0+163 and
//    low after E0+164. Next start accepted from the first IDLE cycle.
//  - start ignored in RUN and DONE; holding start high across several cycles
//    launches one operation only; if still high when back in IDLE, a new
//    operation starts.
//  - A/B may change after the capture edge without affecting the result.
//  - Product holds its value between operations; it changes only at the
//    completion edge (never shows partial results) or on reset.
//  - done is a registered output (state==DONE); no combinational path
//    from inputs to outputs.
//  - No exceptions: 0 * x = 0, 1 * x = x; result is always fully reduced.
// TESTING
//  1. Reset: n_rst=0 -> Product=0, done=0; release away from clk edge.
//  2. A=164'h10101010000, B=164'h50005000, start held 2 cycles ->
//     one done pulse 163 cycles after capture; Product=164'h505000005050000000.
//  3. Reduction: A=1<<162, B=164'h2 -> Product=164'hC9.
//  4. Identity/zero: A=1, B=X -> Product=X (X<2^163); A=0, B=any -> Product=0.
//  5. Start while busy: pulse start again mid-RUN -> ignored, single done,
//     Product per first operands; back-to-back op after IDLE succeeds.
//  6. Reset mid-RUN: n_rst low at iteration ~80 -> done never pulses,
//     Product=0; next start yields correct result.

Source files
------------

// File: rtl/gf163_mult.sv
// Bit-serial GF(2^163) multiplier, polynomial basis, f(x) = x^163 + x^7 + x^6 + x^3 + 1.
// MSB-first Horner evaluation: one bit of B per clock, 163 clocks per product.
module gf163_mult #(
    parameter int NUM_BITS = 163
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS:0]   A,
    input  logic [NUM_BITS:0]   B,
    input  logic                start,
    output logic [NUM_BITS:0]   Product,
    output logic                done
);

    localparam int CNT_W = $clog2(NUM_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);

    // Low-order terms of f(x); x^163 folds back onto x^7 + x^6 + x^3 + 1.
    localparam logic [NUM_BITS-1:0] RED_POLY = {{(NUM_BITS-8){1'b0}}, 8'hC9};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                state;
    logic [NUM_BITS-1:0]   a_reg;
    logic [NUM_BITS-1:0]   b_reg;
    logic [NUM_BITS-1:0]   acc;
    logic [NUM_BITS-1:0]   acc_next;
    logic [CNT_W-1:0]      cnt;

    // acc <- acc * x mod f, then add A when the current multiplier bit is set.
    function automatic logic [NUM_BITS-1:0] horner_step(
        input logic [NUM_BITS-1:0] acc_in,
        input logic [NUM_BITS-1:0] a_in,
        input logic                b_bit
    );
        logic [NUM_BITS-1:0] acc_sh;
        acc_sh = {acc_in[NUM_BITS-2:0], 1'b0};
        if (acc_in[NUM_BITS-1]) begin
            acc_sh = acc_sh ^ RED_POLY;
        end
        return acc_sh ^ (b_bit ? a_in : '0);
    endfunction

    assign acc_next = horner_step(acc, a_reg, b_reg[cnt]);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= ST_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            Product <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= A[NUM_BITS-1:0];
                        b_reg <= B[NUM_BITS-1:0];
                        acc   <= '0;
                        cnt   <= CNT_LAST;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc <= acc_next;
                    // Product is only written here, so it never exposes a partial sum.
                    if (cnt == '0) begin
                        Product <= {1'b0, acc_next};
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf163_mult.sv
// Self-checking bench for gf163_mult against a schoolbook carry-less multiply
// followed by long-division reduction.
module tb_gf163_mult;

    logic         clk;
    logic         n_rst;
    logic [163:0] A;
    logic [163:0] B;
    logic         start;
    logic [163:0] Product;
    logic         done;

    int errors;
    int checks;

    localparam logic [325:0] FPOLY = (326'd1 << 163) | 326'hC9;

    gf163_mult #(.NUM_BITS(163)) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .A       (A),
        .B       (B),
        .start   (start),
        .Product (Product),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [163:0] gf_mul(input logic [163:0] a, input logic [163:0] b);
        logic [325:0] p;
        p = '0;
        for (int i = 0; i < 163; i++) begin
            if (b[i]) p = p ^ ({163'd0, a[162:0]} << i);
        end
        for (int k = 324; k >= 163; k--) begin
            if (p[k]) p = p ^ (FPOLY << (k - 163));
        end
        return {1'b0, p[162:0]};
    endfunction

    function automatic logic [163:0] rand164();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[163:0];
    endfunction

    // Presents operands, holds start for 'hold' edges; returns #1 after the last of them.
    task automatic launch(input logic [163:0] a, input logic [163:0] b, input int hold);
        @(posedge clk); #1;
        A = a;
        B = b;
        start = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_edges, output int lat, output bit got);
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= max_edges; n++) begin
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        #3;
        checks++;
        if (Product !== 164'd0) begin
            errors++;
            $display("FAIL reset_product got=%h exp=0", Product);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
    endtask

    task automatic test_spec_vector();
        int lat;
        bit got;
        int pulses;
        launch(164'h10101010000, 164'h50005000, 2);
        wait_done(400, lat, got);
        checks++;
        if (!got || lat != 162) begin
            errors++;
            $display("FAIL spec_latency got=%0d seen=%0b exp=162", lat, got);
        end
        checks++;
        if (Product !== 164'h505000005050000000) begin
            errors++;
            $display("FAIL spec_product got=%h exp=505000005050000000", Product);
        end
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL spec_single_done extra_pulses=%0d exp=0", pulses);
        end
    endtask

    task automatic test_reduction();
        int lat;
        bit got;
        logic [163:0] a;
        a = 164'd1 << 162;
        launch(a, 164'h2, 1);
        wait_done(400, lat, got);
        checks++;
        if (!got || Product !== 164'hC9) begin
            errors++;
            $display("FAIL reduction got=%h seen=%0b exp=c9", Product, got);
        end
    endtask

    task automatic test_identity_zero();
        int lat;
        bit got;
        logic [163:0] x;
        x = rand164();
        x[163] = 1'b0;
        launch(164'd1, x, 1);
        wait_done(400, lat, got);
        checks++;
        if (!got || Product !== x) begin
            errors++;
            $display("FAIL identity got=%h exp=%h", Product, x);
        end
        x = rand164();
        launch(164'd0, x, 1);
        wait_done(400, lat, got);
        checks++;
        if (!got || Product !== 164'd0) begin
            errors++;
            $display("FAIL zero got=%h exp=0", Product);
        end
    endtask

    task automatic test_random();
        int lat;
        bit got;
        logic [163:0] a;
        logic [163:0] b;
        logic [163:0] exp;
        for (int t = 0; t < 10; t++) begin
            a = rand164();
            b = rand164();
            exp = gf_mul(a, b);
            launch(a, b, 1);
            A = rand164();
            B = rand164();
            wait_done(400, lat, got);
            checks++;
            if (!got || lat != 163) begin
                errors++;
                $display("FAIL rand_latency[%0d] got=%0d seen=%0b exp=163", t, lat, got);
            end
            checks++;
            if (Product !== exp) begin
                errors++;
                $display("FAIL rand_product[%0d] got=%h exp=%h", t, Product, exp);
            end
        end
    endtask

    task automatic test_start_busy();
        int lat;
        bit got;
        int pulses;
        logic [163:0] a;
        logic [163:0] b;
        a = rand164();
        b = rand164();
        launch(a, b, 1);
        repeat (50) begin
            @(posedge clk); #1;
        end
        A = rand164();
        B = rand164();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(400, lat, got);
        checks++;
        if (!got || lat != 112) begin
            errors++;
            $display("FAIL busy_latency got=%0d seen=%0b exp=112", lat, got);
        end
        checks++;
        if (Product !== gf_mul(a, b)) begin
            errors++;
            $display("FAIL busy_product got=%h exp=%h", Product, gf_mul(a, b));
        end
        pulses = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL busy_single_done extra_pulses=%0d exp=0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit got;
        logic [163:0] a1;
        logic [163:0] b1;
        logic [163:0] a2;
        logic [163:0] b2;
        logic [163:0] r1;
        a1 = rand164();
        b1 = rand164();
        a2 = rand164();
        b2 = rand164();
        r1 = gf_mul(a1, b1);
        launch(a1, b1, 1);
        wait_done(400, lat, got);
        checks++;
        if (!got || Product !== r1) begin
            errors++;
            $display("FAIL b2b_first got=%h exp=%h", Product, r1);
        end
        A = a2;
        B = b2;
        start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_width got=%b exp=0", done);
        end
        @(posedge clk); #1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (60) begin
            @(posedge clk); #1;
        end
        checks++;
        if (Product !== r1) begin
            errors++;
            $display("FAIL b2b_hold got=%h exp=%h", Product, r1);
        end
        wait_done(400, lat, got);
        checks++;
        if (!got || lat != 103) begin
            errors++;
            $display("FAIL b2b_latency got=%0d seen=%0b exp=103", lat, got);
        end
        checks++;
        if (Product !== gf_mul(a2, b2)) begin
            errors++;
            $display("FAIL b2b_second got=%h exp=%h", Product, gf_mul(a2, b2));
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit got;
        int pulses;
        logic [163:0] a;
        logic [163:0] b;
        launch(rand164(), rand164(), 1);
        repeat (80) begin
            @(posedge clk); #1;
        end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (Product !== 164'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset product=%h done=%b exp=0/0", Product, done);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        pulses = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0 || Product !== 164'd0) begin
            errors++;
            $display("FAIL midrun_abort pulses=%0d product=%h exp=0/0", pulses, Product);
        end
        a = rand164();
        b = rand164();
        launch(a, b, 1);
        wait_done(400, lat, got);
        checks++;
        if (!got || lat != 163 || Product !== gf_mul(a, b)) begin
            errors++;
            $display("FAIL midrun_recover lat=%0d got=%h exp=%h", lat, Product, gf_mul(a, b));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_spec_vector();
        test_reduction();
        test_identity_zero();
        test_random();
        test_start_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
